// File: rtl/fir_mac_ctrl_nbank.sv
// Control FSM for the multi-bank FIR MAC: routes coefficient writes into NUM_BANK RAMs and
// sequences row reads, MAC enables, final sum and output strobe for every accepted sample.
`timescale 1ns/1ps
module fir_mac_ctrl_nbank #(
  parameter int NUM_BANK = 4,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int CNT_W    = 6
) (
  input  logic                         iClk12M,
  input  logic                         iRsn,
  input  logic                         iEnSample600k,
  input  logic                         iCoeffUpdateFlag,
  input  logic [CNT_W-1:0]             iAddrRam,
  input  logic [DATA_W-1:0]            iWrDtRam,
  input  logic [CNT_W-1:0]             iNumOfCoeff,
  output logic [NUM_BANK-1:0]          oCsnRam,
  output logic [NUM_BANK-1:0]          oWrnRam,
  output logic [NUM_BANK*ADDR_W-1:0]   oAddrRam,
  output logic [NUM_BANK*DATA_W-1:0]   oWrDtRam,
  output logic [NUM_BANK-1:0]          oEnMul,
  output logic [NUM_BANK-1:0]          oEnAcc,
  output logic                         oEnAdd,
  output logic                         oEnDelay,
  output logic                         oEnSum,
  output logic                         oOutValid,
  output logic                         oBusy,
  output logic                         oOverrun
);

  localparam int BANK_W = $clog2(NUM_BANK);
  localparam int NW     = CNT_W + 1;
  localparam logic [NW-1:0] N_MAX = NW'(NUM_BANK * (2**ADDR_W));

  typedef enum logic [2:0] {
    S_IDLE, S_COEFFWR, S_WREND, S_FETCH, S_LOOP, S_FLUSH, S_SUM, S_OUTPUT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [NW-1:0]       n_q, n_d;
  logic                pend_q, pend_d;
  logic                ovr_q, ovr_d;
  logic                flag_q;

  logic [NW-1:0]       n_clamp;
  logic [NW-1:0]       rows;
  logic                busy;
  logic                flag_rise;
  logic                last_row;

  // N needs one bit more than CNT_W so the full-depth tap count is representable.
  assign n_clamp   = (NW'(iNumOfCoeff) > N_MAX) ? N_MAX : NW'(iNumOfCoeff);
  assign rows      = (n_q + NW'(NUM_BANK - 1)) >> BANK_W;
  assign busy      = state_q inside {S_FETCH, S_LOOP, S_FLUSH, S_SUM, S_OUTPUT};
  assign flag_rise = iCoeffUpdateFlag & ~flag_q;
  assign last_row  = (NW'(row_q) + NW'(1)) == rows;

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      n_q     <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      n_q     <= n_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      flag_q  <= iCoeffUpdateFlag;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    n_d     = n_q;
    pend_d  = pend_q;
    ovr_d   = 1'b0;
    case (state_q)
      S_IDLE, S_WREND: begin
        if (iCoeffUpdateFlag) begin
          state_d = S_COEFFWR;
          n_d     = n_clamp;
          ovr_d   = iEnSample600k;
        end else if (iEnSample600k) begin
          state_d = S_FETCH;
        end
      end
      S_COEFFWR: begin
        ovr_d = iEnSample600k;
        if (!iCoeffUpdateFlag) state_d = S_WREND;
      end
      S_FETCH: begin
        row_d   = '0;
        state_d = (rows == '0) ? S_FLUSH : S_LOOP;
      end
      S_LOOP: begin
        row_d = row_q + ADDR_W'(1);
        if (last_row) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_SUM;
      S_SUM:   state_d = S_OUTPUT;
      S_OUTPUT: begin
        pend_d = 1'b0;
        if (iCoeffUpdateFlag && (pend_q || flag_rise)) begin
          state_d = S_COEFFWR;
          n_d     = n_clamp;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (busy && iEnSample600k) ovr_d = 1'b1;
    if (busy && flag_rise && (state_q != S_OUTPUT)) pend_d = 1'b1;
  end

  always_comb begin
    oCsnRam   = '1;
    oWrnRam   = '1;
    oAddrRam  = '0;
    oWrDtRam  = '0;
    oEnMul    = '0;
    oEnAdd    = 1'b0;
    oEnDelay  = 1'b0;
    oEnSum    = 1'b0;
    oOutValid = 1'b0;
    oBusy     = busy;
    case (state_q)
      S_COEFFWR: begin
        // The cycle in which the host drops the flag carries no valid word, so it is not written.
        if (iCoeffUpdateFlag) begin
          for (int b = 0; b < NUM_BANK; b++) begin
            if (BANK_W'(b) == iAddrRam[BANK_W-1:0]) begin
              oCsnRam[b]                     = 1'b0;
              oWrnRam[b]                     = 1'b0;
              oAddrRam[b*ADDR_W +: ADDR_W]   = iAddrRam[BANK_W +: ADDR_W];
              oWrDtRam[b*DATA_W +: DATA_W]   = iWrDtRam;
            end
          end
        end
      end
      S_LOOP: begin
        oCsnRam = '0;
        oEnAdd  = (row_q == '0);
        for (int b = 0; b < NUM_BANK; b++) begin
          oAddrRam[b*ADDR_W +: ADDR_W] = row_q;
          if (((NW'(row_q) << BANK_W) + NW'(b)) < n_q) oEnMul[b] = 1'b1;
        end
      end
      S_FETCH:  oEnDelay  = 1'b1;
      S_SUM:    oEnSum    = 1'b1;
      S_OUTPUT: oOutValid = 1'b1;
      default: ;
    endcase
  end

  assign oEnAcc   = oEnMul;
  assign oOverrun = ovr_q;

endmodule

// File: tb/tb_fir_mac_ctrl_nbank.sv
// Directed bench for fir_mac_ctrl_nbank: expected per-cycle output bundles are queued as
// stimulus is planned and popped/compared once per cycle, half a period after the driving edge.
`timescale 1ns/1ps
module tb_fir_mac_ctrl_nbank;
  localparam int NB = 4, AW = 4, DW = 16, CW = 6;
  localparam int VW = 2*NB + NB*AW + NB*DW + 2*NB + 6;

  logic clk = 1'b0, rst_n = 1'b0, strobe = 1'b0, flag = 1'b0;
  logic [CW-1:0] k_in = '0, ncoeff = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] csn, wrn, mul, acc;
  logic [NB*AW-1:0] addr;
  logic [NB*DW-1:0] wrdt;
  logic add, dly, sum, valid, busy, ovr;
  logic [VW-1:0] obs;
  logic [VW-1:0] exp_q[$];
  logic [DW-1:0] wd;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fir_mac_ctrl_nbank #(.NUM_BANK(NB), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .iClk12M(clk), .iRsn(rst_n), .iEnSample600k(strobe), .iCoeffUpdateFlag(flag),
    .iAddrRam(k_in), .iWrDtRam(wdata), .iNumOfCoeff(ncoeff),
    .oCsnRam(csn), .oWrnRam(wrn), .oAddrRam(addr), .oWrDtRam(wrdt),
    .oEnMul(mul), .oEnAcc(acc), .oEnAdd(add), .oEnDelay(dly), .oEnSum(sum),
    .oOutValid(valid), .oBusy(busy), .oOverrun(ovr));

  assign obs = {csn, wrn, addr, wrdt, mul, acc, add, dly, sum, valid, busy, ovr};

  function automatic logic [VW-1:0] mk(input logic [3:0] c, input logic [3:0] w,
                                       input logic [15:0] a, input logic [63:0] d,
                                       input logic [3:0] m, input logic ad, input logic dl,
                                       input logic sm, input logic vl, input logic bz,
                                       input logic ov);
    return {c, w, a, d, m, m, ad, dl, sm, vl, bz, ov};
  endfunction

  task automatic push_idle(input logic ov);
    exp_q.push_back(mk(4'hF, 4'hF, 16'h0, 64'h0, 4'h0, 0, 0, 0, 0, 0, ov));
  endtask

  task automatic push_wr(input int k, input logic [15:0] d, input logic ov);
    int b = k % 4;
    int r = k / 4;
    logic [3:0] c;
    c = 4'hF & ~(4'b0001 << b);
    exp_q.push_back(mk(c, c, 16'(r) << (4*b), 64'(d) << (16*b), 4'h0, 0, 0, 0, 0, 0, ov));
  endtask

  task automatic push_fetch(input logic ov);
    exp_q.push_back(mk(4'hF, 4'hF, 16'h0, 64'h0, 4'h0, 0, 1, 0, 0, 1, ov));
  endtask

  task automatic push_loop(input int r, input logic [3:0] m, input logic ov);
    logic [3:0] a4;
    a4 = 4'(r);
    exp_q.push_back(mk(4'h0, 4'hF, {4{a4}}, 64'h0, m, (r == 0), 0, 0, 0, 1, ov));
  endtask

  task automatic push_tail();
    exp_q.push_back(mk(4'hF, 4'hF, 16'h0, 64'h0, 4'h0, 0, 0, 0, 0, 1, 0));
    exp_q.push_back(mk(4'hF, 4'hF, 16'h0, 64'h0, 4'h0, 0, 0, 1, 0, 1, 0));
    exp_q.push_back(mk(4'hF, 4'hF, 16'h0, 64'h0, 4'h0, 0, 0, 0, 1, 1, 0));
  endtask

  task automatic push_run(input int r, input logic [3:0] last_mask);
    push_fetch(0);
    for (int i = 0; i < r; i++) push_loop(i, (i == r-1) ? last_mask : 4'hF, 0);
    push_tail();
  endtask

  task automatic step(input string tag);
    logic [VW-1:0] e;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed %h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic tick(input logic s, input string tag);
    strobe = s;
    step(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired: checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    push_idle(0); step("reset");
    rst_n = 1'b1;

    // full-depth coefficient load, N=16
    ncoeff = 6'd16; flag = 1'b1;
    push_idle(0); tick(0, "t1_enter");
    for (int k = 0; k < 16; k++) begin
      wd = 16'($urandom);
      k_in = 6'(k); wdata = wd;
      push_wr(k, wd, 0); tick(0, "t1_wr");
    end
    flag = 1'b0;
    push_idle(0); tick(0, "t1_wr_close");
    push_idle(0); tick(1, "t1_wrend_strobe");

    push_run(4, 4'hF);
    repeat (8) tick(0, "t2_run_n16");

    // flag and strobe together: write window wins, sample flagged as overrun
    ncoeff = 6'd13; flag = 1'b1;
    push_idle(0); tick(1, "t3_flag_and_strobe");
    k_in = 6'd13; wdata = 16'h1234;
    push_wr(13, 16'h1234, 1); tick(0, "t3_wr13_ovr");
    k_in = 6'd14; wdata = 16'hBEEF;
    push_wr(14, 16'hBEEF, 0); tick(0, "t3_wr14");
    flag = 1'b0;
    push_idle(0); tick(0, "t3_close");
    push_idle(0); tick(0, "t3_wrend");
    push_idle(0); tick(1, "t3_strobe");
    push_run(4, 4'b0001);
    repeat (8) tick(0, "t3_run_n13");

    // strobe during busy at t+3
    push_idle(0); tick(1, "t4_strobe");
    push_fetch(0);
    push_loop(0, 4'hF, 0);
    push_loop(1, 4'hF, 0);
    push_loop(2, 4'hF, 1);
    push_loop(3, 4'b0001, 0);
    push_tail();
    for (int i = 1; i <= 8; i++) tick(i == 3, "t4_busy");
    push_idle(0); tick(0, "t4_no_refetch");

    // flag rises mid-LOOP: old N finishes, then write window, then new N=8
    push_idle(0); tick(1, "t5_strobe");
    push_run(4, 4'b0001);
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin flag = 1'b1; ncoeff = 6'd8; end
      tick(0, "t5_busy_old_n");
    end
    k_in = 6'd5; wdata = 16'h5A5A;
    push_wr(5, 16'h5A5A, 0); tick(1, "t5_deferred_wr");
    flag = 1'b0;
    push_idle(1); tick(0, "t5_close_ovr");
    push_idle(0); tick(0, "t5_wrend");
    push_idle(0); tick(1, "t5_strobe_n8");
    push_run(2, 4'hF);
    repeat (6) tick(0, "t5_run_n8");

    // async reset mid-LOOP, then N=0 run
    push_idle(0); tick(1, "t6_strobe");
    push_fetch(0); tick(0, "t6_fetch");
    push_loop(0, 4'hF, 0); tick(0, "t6_loop0");
    rst_n = 1'b0;
    push_idle(0); tick(0, "t6_reset_mid_loop");
    push_idle(0); tick(0, "t6_reset_hold");
    rst_n = 1'b1;
    push_idle(0); tick(0, "t6_idle");
    push_idle(0); tick(1, "t6_strobe_n0");
    push_run(0, 4'h0);
    repeat (4) tick(0, "t6_run_n0");
    push_idle(0); tick(0, "t6_end");

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
